// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter sequencer for the single-cycle core. It holds the fetch
//   address and advances it by one of the following:
//     - a sequential step
//     - a signed relative branch
//     - an absolute jump
//     - a call or return through an internal return-address stack
//   The block has IDLE/RUN/HALT states and a sticky stack-error flag.
//
// Build option:
//   PC_SEQ_CALL_STACK_EN
//     Defined:   the return-address stack is instantiated. CALL pushes
//                pc+1 and RET pops it. Overflow and underflow set
//                stack_err and halt the sequencer.
//     Undefined: there is no stack storage. CALL behaves as JUMP and RET
//                behaves as SEQ. depth and stack_err are tied to 0.
//
// Parameters:
//   PC_WIDTH      width of pc, start_addr and target_abs
//   OFFSET_WIDTH  width of the two's-complement relative offset
//   STACK_DEPTH   number of return-address stack entries (>= 1)
//
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   start       load start_addr and enter RUN (highest priority)
//   start_addr  program entry address
//   next_ins    advance enable; the current instruction retires this cycle
//   op          000 SEQ, 001 BRANCH, 010 JUMP, 011 CALL, 100 RET, others SEQ
//   cond        branch condition (BRANCH only)
//   offset      signed relative displacement
//   target_abs  absolute target for JUMP and CALL
//   halt        stop request (honoured in RUN)
//   pc          registered fetch address
//   running     state == RUN
//   halted      state == HALT
//   stack_err   sticky overflow/underflow flag
//   depth       current stack occupancy
//
// States:
//   state  | meaning
//   IDLE   | after reset; pc held, waiting for start
//   RUN    | fetching; pc advances whenever next_ins is high
//   HALT   | stopped by halt or by a stack error; only start exits
module pc_sequencer #(
  parameter int PC_WIDTH     = 12,
  parameter int OFFSET_WIDTH = 8,
  parameter int STACK_DEPTH  = 4,
  localparam int DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [PC_WIDTH-1:0]     start_addr,
  input  logic                    next_ins,
  input  logic [2:0]              op,
  input  logic                    cond,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic [PC_WIDTH-1:0]     target_abs,
  input  logic                    halt,
  output logic [PC_WIDTH-1:0]     pc,
  output logic                    running,
  output logic                    halted,
  output logic                    stack_err,
  output logic [DW-1:0]           depth
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_branch;
  logic [PC_WIDTH-1:0] offset_ext;

  // The size cast of a signed operand sign-extends it. All pc arithmetic
  // wraps modulo 2^PC_WIDTH.
  assign offset_ext = PC_WIDTH'($signed(offset));
  assign pc_inc     = pc_q + PC_WIDTH'(1);
  assign pc_branch  = pc_inc + offset_ext;

`ifdef PC_SEQ_CALL_STACK_EN
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [DW-1:0]       depth_q, depth_d;
  logic                err_q, err_d;
  logic                push;
  logic                stack_full, stack_empty;
  logic [AW-1:0]       push_idx, pop_idx;

  assign stack_full  = (depth_q == DW'(STACK_DEPTH));
  assign stack_empty = (depth_q == '0);
  // Truncation is safe here. A push only happens below full, and a pop
  // only happens above empty, so both indices stay in range.
  assign push_idx    = AW'(depth_q);
  assign pop_idx     = AW'(depth_q - DW'(1));

  // Stack contents need no reset. depth alone decides which entries are
  // valid.
  always_ff @(posedge clock) begin
    if (push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  assign depth     = depth_q;
  assign stack_err = err_q;
`else
  assign depth     = '0;
  assign stack_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_SEQ_CALL_STACK_EN
    depth_d = depth_q;
    err_d   = err_q;
    push    = 1'b0;
`endif
    if (start) begin
      state_d = S_RUN;
      pc_d    = start_addr;
`ifdef PC_SEQ_CALL_STACK_EN
      depth_d = '0;
      err_d   = 1'b0;
`endif
    end else if (state_q == S_RUN) begin
      if (halt) begin
        state_d = S_HALT;
      end else if (next_ins) begin
        case (op)
          OP_BRANCH: pc_d = cond ? pc_branch : pc_inc;
          OP_JUMP:   pc_d = target_abs;
          OP_CALL: begin
`ifdef PC_SEQ_CALL_STACK_EN
            // On overflow, pc and the stack stay frozen; the error flag
            // is raised and the sequencer halts.
            if (stack_full) begin
              err_d   = 1'b1;
              state_d = S_HALT;
            end else begin
              push    = 1'b1;
              depth_d = depth_q + DW'(1);
              pc_d    = target_abs;
            end
`else
            pc_d = target_abs;
`endif
          end
          OP_RET: begin
`ifdef PC_SEQ_CALL_STACK_EN
            if (stack_empty) begin
              err_d   = 1'b1;
              state_d = S_HALT;
            end else begin
              depth_d = depth_q - DW'(1);
              pc_d    = stack_mem[pop_idx];
            end
`else
            pc_d = pc_inc;
`endif
          end
          default: pc_d = pc_inc;
        endcase
      end
    end
  end

  assign pc      = pc_q;
  assign running = (state_q == S_RUN);
  assign halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int PC_WIDTH     = 12;
  localparam int OFFSET_WIDTH = 8;
  localparam int STACK_DEPTH  = 4;
  localparam int DW           = $clog2(STACK_DEPTH + 1);

`ifdef PC_SEQ_CALL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  localparam logic [2:0] SEQ = 3'b000, BR = 3'b001, JMP = 3'b010,
                         CALL = 3'b011, RET = 3'b100;

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic                    start;
  logic [PC_WIDTH-1:0]     start_addr;
  logic                    next_ins;
  logic [2:0]              op;
  logic                    cond;
  logic [OFFSET_WIDTH-1:0] offset;
  logic [PC_WIDTH-1:0]     target_abs;
  logic                    halt;
  logic [PC_WIDTH-1:0]     pc;
  logic                    running;
  logic                    halted;
  logic                    stack_err;
  logic [DW-1:0]           depth;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .PC_WIDTH    (PC_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .start_addr(start_addr),
    .next_ins  (next_ins),
    .op        (op),
    .cond      (cond),
    .offset    (offset),
    .target_abs(target_abs),
    .halt      (halt),
    .pc        (pc),
    .running   (running),
    .halted    (halted),
    .stack_err (stack_err),
    .depth     (depth)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full output snapshot: pc, running, halted, stack_err, depth.
  task automatic chk_all(input string tag, input logic [PC_WIDTH-1:0] e_pc,
                         input logic e_run, input logic e_halt,
                         input logic e_err, input logic [DW-1:0] e_depth);
    chk({tag, ".pc"},      32'(pc),        32'(e_pc));
    chk({tag, ".running"}, 32'(running),   32'(e_run));
    chk({tag, ".halted"},  32'(halted),    32'(e_halt));
    chk({tag, ".err"},     32'(stack_err), 32'(e_err));
    chk({tag, ".depth"},   32'(depth),     32'(e_depth));
  endtask

  // Drive one cycle of inputs, let the edge take them, and settle.
  task automatic cyc(input logic st, input logic [PC_WIDTH-1:0] sa,
                     input logic ni, input logic [2:0] o, input logic c,
                     input logic [OFFSET_WIDTH-1:0] off,
                     input logic [PC_WIDTH-1:0] tgt, input logic h);
    start = st; start_addr = sa; next_ins = ni; op = o; cond = c;
    offset = off; target_abs = tgt; halt = h;
    @(posedge clock);
    #1;
  endtask

  task automatic go(input logic [PC_WIDTH-1:0] sa);
    cyc(1'b1, sa, 1'b0, SEQ, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic adv(input logic [2:0] o, input logic c,
                     input logic [OFFSET_WIDTH-1:0] off, input logic [PC_WIDTH-1:0] tgt);
    cyc(1'b0, '0, 1'b1, o, c, off, tgt, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; start_addr = '0; next_ins = 1'b1; op = SEQ;
    cond = 1'b0; offset = '0; target_abs = '0; halt = 1'b0;
    #12;
    chk_all("reset", 12'h000, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adv(SEQ, 0, 8'h00, 12'h000);
      chk_all("idle_ignore", 12'h000, 0, 0, 0, 0);
    end

    // Start and sequence.
    go(12'h100);
    chk_all("start", 12'h100, 1, 0, 0, 0);
    adv(SEQ, 0, 8'h00, 12'h000); chk("seq1", 32'(pc), 32'h101);
    adv(SEQ, 0, 8'h00, 12'h000); chk("seq2", 32'(pc), 32'h102);
    adv(SEQ, 0, 8'h00, 12'h000); chk("seq3", 32'(pc), 32'h103);
    cyc(1'b0, '0, 1'b0, JMP, 1'b0, '0, 12'h555, 1'b0);
    chk("hold_no_next", 32'(pc), 32'h103);

    // Branches and wrap.
    go(12'h010);
    adv(BR, 1, 8'h05, 12'h000); chk("br_fwd", 32'(pc), 32'h016);
    adv(BR, 1, 8'hF0, 12'h000); chk("br_back", 32'(pc), 32'h007);
    adv(BR, 0, 8'hF0, 12'h000); chk("br_not_taken", 32'(pc), 32'h008);
    go(12'hFFF);
    adv(SEQ, 0, 8'h00, 12'h000); chk("seq_wrap", 32'(pc), 32'h000);
    adv(3'b101, 1, 8'h40, 12'h777); chk("op101_seq", 32'(pc), 32'h001);
    go(12'h000);
    adv(BR, 1, 8'hFE, 12'h000); chk("br_wrap", 32'(pc), 32'hFFF);

    // Call/return nesting; without the stack CALL=JUMP and RET=SEQ.
    go(12'h020);
    adv(CALL, 0, 8'h00, 12'h200);
    chk_all("call1", 12'h200, 1, 0, 0, STK ? 3'd1 : 3'd0);
    adv(CALL, 0, 8'h00, 12'h300);
    chk_all("call2", 12'h300, 1, 0, 0, STK ? 3'd2 : 3'd0);
    adv(RET, 0, 8'h00, 12'h000);
    chk_all("ret1", STK ? 12'h201 : 12'h301, 1, 0, 0, STK ? 3'd1 : 3'd0);
    adv(RET, 0, 8'h00, 12'h000);
    chk_all("ret2", STK ? 12'h021 : 12'h302, 1, 0, 0, 0);
    adv(JMP, 0, 8'h00, 12'h456); chk("jump", 32'(pc), 32'h456);

    // Overflow.
    go(12'h000);
    adv(CALL, 0, 8'h00, 12'h400);
    adv(CALL, 0, 8'h00, 12'h410);
    adv(CALL, 0, 8'h00, 12'h420);
    adv(CALL, 0, 8'h00, 12'h430);
    chk_all("call4", 12'h430, 1, 0, 0, STK ? 3'd4 : 3'd0);
    adv(CALL, 0, 8'h00, 12'h440);
    chk_all("overflow", STK ? 12'h430 : 12'h440, !STK, STK, STK, STK ? 3'd4 : 3'd0);
    adv(SEQ, 0, 8'h00, 12'h000);
    chk("after_overflow", 32'(pc), STK ? 32'h430 : 32'h441);

    // Underflow, then start clears the error.
    go(12'h050);
    chk_all("start_clears", 12'h050, 1, 0, 0, 0);
    adv(RET, 0, 8'h00, 12'h000);
    chk_all("underflow", STK ? 12'h050 : 12'h051, !STK, STK, STK, 0);
    go(12'h060);
    chk_all("restart", 12'h060, 1, 0, 0, 0);

    // Back-to-back CALL then RET.
    adv(CALL, 0, 8'h00, 12'h700); chk("b2b_call", 32'(pc), 32'h700);
    adv(RET, 0, 8'h00, 12'h000);
    chk_all("b2b_ret", STK ? 12'h061 : 12'h701, 1, 0, 0, 0);

    // Halt beats next_ins/op.
    go(12'h080);
    cyc(1'b0, '0, 1'b1, JMP, 1'b0, '0, 12'h3AB, 1'b1);
    chk_all("halt_prio", 12'h080, 0, 1, 0, 0);
    adv(JMP, 0, 8'h00, 12'h3AB);
    chk_all("halt_ignore", 12'h080, 0, 1, 0, 0);
    // start beats halt.
    cyc(1'b1, 12'h090, 1'b1, JMP, 1'b0, '0, 12'h3AB, 1'b1);
    chk_all("start_over_halt", 12'h090, 1, 0, 0, 0);

    // Asynchronous reset mid-run, applied away from any edge.
    adv(SEQ, 0, 8'h00, 12'h000);
    chk("pre_async", 32'(pc), 32'h091);
    #2 reset_n = 1'b0;
    #1;
    chk_all("async_reset", 12'h000, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    adv(SEQ, 0, 8'h00, 12'h000);
    chk_all("post_reset_idle", 12'h000, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle core, the next-generation PC block. It holds the fetch address and advances it by sequential step, signed relative branch, absolute jump, or call/return through an internal return-address stack. It also has explicit IDLE/RUN/HALT states with a sticky stack-error flag. It sits between the control decoder (op, condition, offsets) and instruction memory (pc).

## Interface
Parameters:
- PC_WIDTH, 12, width of pc, start_addr, target_abs
- OFFSET_WIDTH, 8, width of signed relative offset (two's complement)
- STACK_DEPTH, 4, return-address stack entries (≥1)

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  load start_addr and enter RUN
- start_addr  in  PC_WIDTH  program entry address
- next_ins  in  1  advance enable (current instruction retires this cycle)
- op  in  3  000 SEQ, 001 BRANCH, 010 JUMP, 011 CALL, 100 RET, 101–111 treated as SEQ
- cond  in  1  branch condition, used only by BRANCH
- offset  in  OFFSET_WIDTH  signed relative displacement
- target_abs  in  PC_WIDTH  absolute target for JUMP/CALL
- halt  in  1  stop request
- pc  out  PC_WIDTH  current fetch address (registered)
- running  out  1  state == RUN
- halted  out  1  state == HALT
- stack_err  out  1  sticky overflow/underflow flag
- depth  out  $clog2(STACK_DEPTH+1)  current stack occupancy

## Operation
- States: IDLE (after reset), RUN, HALT.
- Reset (reset_n low, asynchronous): pc=0, state=IDLE, depth=0, stack_err=0, running=0, halted=0. Stack contents don't care.
- Priority each edge: start > halt > next_ins/op.
- start (any state): pc←start_addr, depth←0, stack_err←0, state←RUN.
- halt in RUN (no start): state←HALT, pc held, op ignored.
- IDLE/HALT: next_ins and op are ignored. pc is held. Exit is only via start.
- RUN with next_ins=0: pc held, stack unchanged.
- RUN with next_ins=1:
  - SEQ: pc←pc+1.
  - BRANCH: if cond, pc←pc+1+sext(offset); else pc+1.
  - JUMP: pc←target_abs.
  - CALL: push pc+1, pc←target_abs, depth+1.
  - RET: pop, pc←top entry, depth−1.
- Arithmetic: all PC math is modulo 2^PC_WIDTH (wrap, no flag). offset is sign-extended to PC_WIDTH before the add. Example: PC_WIDTH=12, pc=0x000, offset=0xFE → pc=0xFFF.
- CALL at depth==STACK_DEPTH (overflow) or RET at depth==0 (underflow):
  - stack_err←1, state←HALT.
  - pc and stack unchanged.
- stack_err clears only on start or reset.

## Timing
- All outputs are registered. Their new values are visible after the rising edge that samples the inputs, giving 1-cycle latency.
- running, halted and depth are decoded from registered state, so they carry no combinational path from inputs.
- Inputs are sampled only at the rising edge of clock. No handshake: next_ins is a level qualifier per cycle.
- Back-to-back CALL/RET on consecutive cycles is supported. A RET immediately after a CALL returns to the CALL's pc+1.
- Asserting reset_n low mid-operation forces the reset values immediately, without waiting for a clock edge. Release is synchronised externally.

## Configuration
- Macro PC_SEQ_CALL_STACK_EN.
- Defined: the return-address stack, CALL/RET, depth and stack_err behave as specified above.
- Undefined: no stack storage is instantiated.
  - CALL behaves as JUMP. RET behaves as SEQ.
  - depth and stack_err are tied to 0. The overflow/underflow HALT transitions do not exist.

## Test plan
- Reset then idle: hold reset_n=0, then release with next_ins=1, op=SEQ for 3 cycles → pc=0x000, running=0, halted=0 throughout.
- Start and sequence: start=1, start_addr=0x100, then 3 cycles next_ins=1, op=SEQ → pc 0x100, 0x101, 0x102, 0x103. A cycle with next_ins=0 holds 0x103.
- Branches: pc=0x010, BRANCH cond=1 offset=0x05 → 0x016. At pc=0x016, offset=0xF0 (−16) → 0x007. cond=0 → 0x008. At pc=0xFFF, SEQ → 0x000 (wrap).
- Call/return nesting (STACK_DEPTH=4): from pc=0x020, CALL 0x200, CALL 0x300 → depth=2. Two RETs → pc=0x201 then 0x021, depth=0.
- Stack errors: 4 CALLs then a 5th CALL → stack_err=1, halted=1, pc unchanged, depth=4. Separately, start then RET at depth 0 → stack_err=1, halted=1. A subsequent start=1 clears stack_err and sets running=1.
- Halt priority: in RUN assert halt and next_ins with op=JUMP 0x3AB in the same cycle → halted=1, pc unchanged. Further next_ins is ignored until start.
